// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART constants: parity selection, transmitter state encoding, parity helper.
package uart_constants;

   typedef enum logic [2:0] {
      UART_PARITY_NONE  = 3'd0,
      UART_PARITY_EVEN  = 3'd1,
      UART_PARITY_ODD   = 3'd2,
      UART_PARITY_MARK  = 3'd3,
      UART_PARITY_SPACE = 3'd4
   } uart_parity_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   // Parity bit for a frame, given the XOR reduction of its data bits.
   function automatic logic parity_bit(input uart_parity_e pt, input logic data_xor);
      logic p;
      case (pt)
         UART_PARITY_EVEN: p = data_xor;
         UART_PARITY_ODD:  p = ~data_xor;
         UART_PARITY_MARK: p = 1'b1;
         default:          p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Transmit FIFO: power-of-two depth, wrapping pointers, occupancy counter.
module uart_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           head_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Qualify requests and compute next pointers and occupancy.
   always_comb begin
      push_ok  = push_i && !full_o;
      pop_ok   = pop_i && !empty_o;
      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   // Pointer and counter registers; reset discards all queued entries.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; a write coincident with reset is dropped.
   always_ff @(posedge clock) begin
      if (push_ok && !reset) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO front end, runtime baud divisor, registered tx.
module uart_tx_buffered
   import uart_constants::*;
#(
   parameter int unsigned  DATA_WIDTH  = 8,
   parameter int unsigned  FIFO_DEPTH  = 16,
   parameter int unsigned  DIV_WIDTH   = 16,
   parameter uart_parity_e PARITY_TYPE = UART_PARITY_NONE,
   parameter int unsigned  STOP_BITS   = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [DATA_WIDTH-1:0]         data,
   input  logic                          data_valid,
   output logic                          data_ready,
   input  logic [DIV_WIDTH-1:0]          divisor,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

   uart_state_e            state_q, state_d;
   logic                   tx_q, tx_d;
   logic [DATA_WIDTH-1:0]  shift_q, shift_d;
   logic [DIV_WIDTH-1:0]   baud_q, baud_d;
   logic [DIV_WIDTH-1:0]   div_q, div_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   stop_q, stop_d;
   logic                   par_q, par_d;
   logic                   load, bit_end;

   logic                   fifo_pop, fifo_full, fifo_empty;
   logic [DATA_WIDTH-1:0]  fifo_head;
   logic [CNT_W-1:0]       fifo_cnt;

   uart_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (data_valid),
      .wdata_i (data),
      .pop_i   (fifo_pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   assign data_ready = !fifo_full;
   assign busy       = (state_q != ST_IDLE) || !fifo_empty;
   assign fifo_count = fifo_cnt;
   assign tx         = tx_q;
   assign bit_end    = (baud_q == div_q - DIV_WIDTH'(1));

   // Next-state logic: frame sequencing, bit timing and FIFO pop/load.
   always_comb begin
      state_d  = state_q;
      tx_d     = tx_q;
      shift_d  = shift_q;
      baud_d   = baud_q;
      div_d    = div_q;
      idx_d    = idx_q;
      stop_d   = stop_q;
      par_d    = par_q;
      fifo_pop = 1'b0;
      load     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) load = 1'b1;
         end
         ST_START: begin
            if (bit_end) begin
               baud_d  = '0;
               idx_d   = '0;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q + DIV_WIDTH'(1);
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                  if (PARITY_TYPE != UART_PARITY_NONE) begin
                     tx_d    = par_q;
                     state_d = ST_PARITY;
                  end else begin
                     tx_d    = 1'b1;
                     stop_d  = 1'b0;
                     state_d = ST_STOP;
                  end
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end else begin
               baud_d = baud_q + DIV_WIDTH'(1);
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               baud_d  = '0;
               tx_d    = 1'b1;
               stop_d  = 1'b0;
               state_d = ST_STOP;
            end else begin
               baud_d = baud_q + DIV_WIDTH'(1);
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (stop_q == 1'(STOP_BITS - 1)) begin
                  if (!fifo_empty) begin
                     load = 1'b1;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = ST_IDLE;
                  end
               end else begin
                  stop_d = 1'b1;
               end
            end else begin
               baud_d = baud_q + DIV_WIDTH'(1);
            end
         end
         default: begin
            tx_d    = 1'b1;
            baud_d  = '0;
            idx_d   = '0;
            stop_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      // Pop the head, latch byte/divisor/parity and begin the start bit.
      if (load) begin
         fifo_pop = 1'b1;
         shift_d  = fifo_head;
         div_d    = (divisor == '0) ? DIV_WIDTH'(1) : divisor;
         par_d    = parity_bit(PARITY_TYPE, ^fifo_head);
         tx_d     = 1'b0;
         baud_d   = '0;
         state_d  = ST_START;
      end
   end

   // State and datapath registers; reset aborts any frame in progress.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         tx_q    <= 1'b1;
         shift_q <= '0;
         baud_q  <= '0;
         div_q   <= DIV_WIDTH'(1);
         idx_q   <= '0;
         stop_q  <= 1'b0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         shift_q <= shift_d;
         baud_q  <= baud_d;
         div_q   <= div_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
         par_q   <= par_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench: frames decoded against a bit-list model built from each byte.
module tb_uart_tx_buffered;
   import uart_constants::*;

   logic        clock;
   logic        reset;
   logic [7:0]  data;
   logic        data_valid;
   logic        data_ready;
   logic [15:0] divisor;
   logic        busy;
   logic [4:0]  fifo_count;

   logic [7:0]  data_p;
   logic        valid_p;
   logic [15:0] div_p;
   logic [3:0]  busy_p;
   logic [3:0]  ready_p;
   logic [4:0]  cnt_p [4];

   logic [4:0]  tx_all;

   int n_cmp  = 0;
   int n_fail = 0;
   int acc;
   logic [7:0] exp_q [$];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   uart_tx_buffered u_dut (
      .clock      (clock),
      .reset      (reset),
      .data       (data),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .divisor    (divisor),
      .tx         (tx_all[0]),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   function automatic uart_parity_e pt_of(input int g);
      case (g)
         0:       return UART_PARITY_EVEN;
         1:       return UART_PARITY_ODD;
         2:       return UART_PARITY_MARK;
         default: return UART_PARITY_SPACE;
      endcase
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_par
      uart_tx_buffered #(
         .PARITY_TYPE (pt_of(g)),
         .STOP_BITS   ((g < 2) ? 2 : 1)
      ) u_p (
         .clock      (clock),
         .reset      (reset),
         .data       (data_p),
         .data_valid (valid_p),
         .data_ready (ready_p[g]),
         .divisor    (div_p),
         .tx         (tx_all[g+1]),
         .busy       (busy_p[g]),
         .fifo_count (cnt_p[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Enqueue one byte on the main DUT, starting at a negedge; ends at the next negedge.
   task automatic push_byte(input logic [7:0] b);
      data       = b;
      data_valid = 1'b1;
      check("push_ready", 32'(data_ready), 32'd1);
      exp_q.push_back(b);
      @(negedge clock);
      data_valid = 1'b0;
   endtask

   // Find the next start bit on tx_all[sel] and check every bit period of the frame.
   // par: 0 none, 1 even, 2 odd, 3 mark, 4 space. b_in < 0 takes the byte from exp_q.
   task automatic check_next(input int sel, input int div, input int b_in, input bit imm,
                             input int par, input int stops, input string tag);
      logic        v;
      logic [31:0] bv;
      logic        bits [16];
      int          nb;
      int          waited;
      int          match;
      @(negedge clock);
      v = tx_all[sel];
      waited = 0;
      if (!imm) begin
         while (v !== 1'b0 && waited < 300) begin
            @(negedge clock);
            v = tx_all[sel];
            waited++;
         end
      end
      check($sformatf("%s start", tag), 32'(v), 32'd0);
      if (v !== 1'b0) return;
      if (b_in < 0) begin
         check($sformatf("%s queued", tag), 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() == 0) return;
         bv = 32'(exp_q.pop_front());
      end else begin
         bv = 32'(b_in);
      end
      nb = 0;
      bits[nb++] = 1'b0;
      for (int i = 0; i < 8; i++) bits[nb++] = bv[i];
      case (par)
         1: bits[nb++] = ($countones(bv[7:0]) % 2) == 1;
         2: bits[nb++] = ($countones(bv[7:0]) % 2) == 0;
         3: bits[nb++] = 1'b1;
         4: bits[nb++] = 1'b0;
         default: ;
      endcase
      for (int s = 0; s < stops; s++) bits[nb++] = 1'b1;
      for (int k = 0; k < nb; k++) begin
         match = 0;
         for (int c = 0; c < div; c++) begin
            if (!(k == 0 && c == 0)) begin
               @(negedge clock);
               v = tx_all[sel];
            end
            if (v === bits[k]) match++;
         end
         check($sformatf("%s byte %02h bit%0d cycles", tag, bv[7:0], k), 32'(match), 32'(div));
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      data       = '0;
      data_valid = 1'b0;
      divisor    = 16'd4;
      data_p     = '0;
      valid_p    = 1'b0;
      div_p      = 16'd3;
      repeat (3) @(negedge clock);

      // Reset state
      check("rst tx_all", 32'(tx_all), 32'h1f);
      check("rst fifo_count", 32'(fifo_count), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst data_ready", 32'(data_ready), 32'd1);
      check("rst parity busy", 32'(busy_p), 32'd0);
      check("rst parity ready", 32'(ready_p), 32'hf);
      check("rst parity cnt0", 32'(cnt_p[0]), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // 8N1 0xA5 at divisor 4; tx falls one edge after the accepting edge
      divisor = 16'd4;
      push_byte(8'hA5);
      check("a5 no fall at accept", 32'(tx_all[0]), 32'd1);
      check("a5 count after accept", 32'(fifo_count), 32'd1);
      check_next(0, 4, -1, 1'b1, 0, 1, "a5");
      @(negedge clock);
      check("a5 busy after stop", 32'(busy), 32'd0);
      check("a5 idle tx", 32'(tx_all[0]), 32'd1);

      // Random single bytes with random divisors
      for (int i = 0; i < 3; i++) begin
         int d;
         d = int'($urandom_range(1, 6));
         divisor = 16'(d);
         push_byte(8'($urandom));
         check_next(0, d, -1, 1'b1, 0, 1, "rand");
         @(negedge clock);
         check("rand busy idle", 32'(busy), 32'd0);
      end

      // Back-to-back frames with no idle clock between them
      divisor = 16'd2;
      fork
         begin
            push_byte(8'h11);
            push_byte(8'h22);
         end
         begin
            check_next(0, 2, -1, 1'b0, 0, 1, "b2b first");
            check_next(0, 2, -1, 1'b1, 0, 1, "b2b second");
         end
      join
      @(negedge clock);
      check("b2b busy idle", 32'(busy), 32'd0);

      // Hold data_valid for 20 cycles: 16 queued plus 1 in flight accepted
      divisor = 16'd2;
      acc = 0;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               data       = 8'($urandom);
               data_valid = 1'b1;
               if (data_ready) begin
                  exp_q.push_back(data);
                  acc++;
               end
               @(negedge clock);
            end
            data_valid = 1'b0;
            check("fill accepted", 32'(acc), 32'd17);
            check("fill count", 32'(fifo_count), 32'd16);
            check("fill ready low", 32'(data_ready), 32'd0);
         end
         begin
            for (int i = 0; i < 17; i++) check_next(0, 2, -1, i > 0, 0, 1, "fill");
         end
      join
      @(negedge clock);
      check("fill busy idle", 32'(busy), 32'd0);
      check("fill queue drained", 32'(exp_q.size()), 32'd0);

      // Reset mid-DATA with 3 bytes queued; a push coincident with reset is dropped
      divisor = 16'd4;
      push_byte(8'h00);
      for (int i = 0; i < 3; i++) push_byte(8'($urandom));
      check("midrst queued", 32'(fifo_count), 32'd3);
      repeat (3) @(negedge clock);
      check("midrst in data", 32'(tx_all[0]), 32'd0);
      reset      = 1'b1;
      data       = 8'h5A;
      data_valid = 1'b1;
      @(negedge clock);
      check("midrst tx", 32'(tx_all[0]), 32'd1);
      check("midrst count", 32'(fifo_count), 32'd0);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst ready", 32'(data_ready), 32'd1);
      reset      = 1'b0;
      data_valid = 1'b0;
      @(negedge clock);
      check("midrst push dropped", 32'(fifo_count), 32'd0);
      check("midrst still idle", 32'(busy), 32'd0);
      exp_q.delete();
      push_byte(8'($urandom));
      check_next(0, 4, -1, 1'b1, 0, 1, "after rst");
      @(negedge clock);
      check("after rst idle", 32'(busy), 32'd0);

      // Divisor change mid-frame applies only from the next start bit
      divisor = 16'd4;
      fork
         begin
            push_byte(8'($urandom));
            push_byte(8'($urandom));
            repeat (6) @(negedge clock);
            divisor = 16'd8;
         end
         begin
            check_next(0, 4, -1, 1'b0, 0, 1, "div4");
            check_next(0, 8, -1, 1'b1, 0, 1, "div8");
         end
      join
      @(negedge clock);
      check("div busy idle", 32'(busy), 32'd0);
      divisor = 16'd0;
      push_byte(8'($urandom));
      check_next(0, 1, -1, 1'b1, 0, 1, "div0");
      @(negedge clock);
      check("div0 busy idle", 32'(busy), 32'd0);

      // Parity variants: 0x07 then a random byte on all four parity instances
      for (int r = 0; r < 2; r++) begin
         int pb;
         int pd;
         pb = (r == 0) ? 32'h07 : int'($urandom_range(0, 255));
         pd = (r == 0) ? 3 : int'($urandom_range(1, 4));
         div_p = 16'(pd);
         fork
            begin
               data_p  = 8'(pb);
               valid_p = 1'b1;
               @(negedge clock);
               valid_p = 1'b0;
            end
            begin
               fork
                  check_next(1, pd, pb, 1'b0, 1, 2, "even");
                  check_next(2, pd, pb, 1'b0, 2, 2, "odd");
                  check_next(3, pd, pb, 1'b0, 3, 1, "mark");
                  check_next(4, pd, pb, 1'b0, 4, 1, "space");
               join
            end
         join
         repeat (2) @(negedge clock);
         check("parity busy idle", 32'(busy_p), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: data bits per frame, legal range 5-9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: transmit buffer entries, a power of 2 and at least 2.
REQ-003 SHALL have parameter DIV_WIDTH, default 16: width of the runtime baud divisor.
REQ-004 SHALL have parameter PARITY_TYPE, default UART_PARITY_NONE: one of NONE, EVEN, ODD, MARK or SPACE.
REQ-005 SHALL have parameter STOP_BITS, default 1: stop bits per frame, legal range 1-2.
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port data, input, DATA_WIDTH bits: byte to enqueue.
REQ-009 SHALL have port data_valid, input, 1 bit: enqueue request.
REQ-010 SHALL have port data_ready, output, 1 bit: high when the FIFO can accept a byte.
REQ-011 SHALL have port divisor, input, DIV_WIDTH bits: clocks per bit period; a value of 0 is treated as 1.
REQ-012 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-013 SHALL have port busy, output, 1 bit: high when the FSM is not IDLE or the FIFO is not empty.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: number of entries currently queued.

Function
REQ-015 A byte SHALL be written to the FIFO on each rising edge where data_valid and data_ready are both high.
REQ-016 data_ready SHALL equal (fifo_count != FIFO_DEPTH); a push while full SHALL be impossible, and no pass-through SHALL occur when the FIFO is full.
REQ-017 A simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; any other encoding SHALL return to IDLE.
REQ-019 In IDLE with the FIFO not empty, the FSM SHALL pop the head on one edge, latch the byte and divisor, enter START and drive tx low on that same edge.
REQ-020 A byte pushed into an empty FIFO while the FSM is IDLE SHALL drive tx low one edge after the accepting edge.
REQ-021 Each bit SHALL be held for exactly max(divisor,1) clocks, timed by a bit counter that counts from 0 to divisor-1 and then resets.
REQ-022 DATA SHALL shift bits out LSB first, DATA_WIDTH bits, tracked by a bit index counter.
REQ-023 PARITY SHALL be entered only when PARITY_TYPE != NONE, and the parity bit SHALL be: EVEN = XOR of the data bits, ODD = inverse of that XOR, MARK = 1, SPACE = 0.
REQ-024 STOP SHALL drive tx high for STOP_BITS bit periods.
REQ-025 At the end of the last stop bit, the FSM SHALL enter START directly (no idle clock) if the FIFO is not empty, and SHALL enter IDLE otherwise.
REQ-026 Changes on divisor mid-frame SHALL NOT affect the current frame; the latched value applies until the next START.
REQ-027 tx SHALL be a registered output and SHALL be high in IDLE.
REQ-028 The byte being transmitted SHALL be held in an internal shift register, so FIFO contents and the data input may change freely mid-frame.

Reset
REQ-029 While reset is high at a rising edge: state SHALL become IDLE, tx SHALL become 1, fifo_count SHALL become 0, pointers and counters SHALL become 0, busy SHALL become 0 and data_ready SHALL become 1.
REQ-030 Reset asserted mid-frame SHALL abort the frame; tx SHALL be high on the next edge and queued bytes SHALL be discarded.
REQ-031 A push coincident with reset SHALL be dropped.

Structure
REQ-032 The UART_CONSTANTS package SHALL hold the parity-type enumeration (UART_PARITY_NONE/EVEN/ODD/MARK/SPACE) and the FSM state encoding.
REQ-033 The FIFO SHALL be a separate sub-module, uart_fifo, parameterised by WIDTH and DEPTH, with push/pop/full/empty/count.
REQ-034 The FSM, bit counter and shift register SHALL reside in uart_tx_buffered.

Verification
REQ-035 8N1, divisor=4, push 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; falls 1 edge after accept; busy drops after stop.
REQ-036 PARITY_TYPE=EVEN, divisor=3, push 0x07 -> parity bit 1; with ODD -> 0; MARK -> 1; SPACE -> 0.
REQ-037 Push 0x11 and 0x22 back-to-back, divisor=2 -> second start bit immediately follows first stop bit, no idle clock.
REQ-038 Hold data_valid for 20 cycles while transmitting, FIFO_DEPTH=16 -> data_ready low once fifo_count=16, exactly 16 entries plus 1 in flight accepted, all sent in order.
REQ-039 Assert reset mid-DATA with 3 bytes queued -> next edge tx=1, fifo_count=0, busy=0; a new push transmits normally.
REQ-040 Change divisor 4->8 mid-frame, 2 bytes queued -> first frame keeps 4-clock bits; second frame uses 8-clock bits; divisor=0 yields 1-clock bits.
